// File: rtl/uart_baud_gen.sv
// UART bit-rate generator: programmable integer+fractional divisor, selectable strobe phase,
// and a frame bit counter with an end-of-frame pulse.
module uart_baud_gen #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned FRAC_W      = 4,
    parameter int unsigned DIV_DEFAULT = 52,
    parameter int unsigned FRAME_BITS  = 10,
    parameter int unsigned IDX_W       = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Count_Sig,
    input  logic              Phase_Mode,
    input  logic              Div_Wr,
    input  logic [CNT_W-1:0]  Div_Int,
    input  logic [FRAC_W-1:0] Div_Frac,
    output logic              BPS_CLK,
    output logic [IDX_W-1:0]  Bit_Idx,
    output logic              Frame_Done,
    output logic              Wr_Err
);

    localparam logic [CNT_W-1:0] DivDefault = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] DivMin     = CNT_W'(2);
    localparam logic [IDX_W-1:0] LastIdx    = IDX_W'(FRAME_BITS - 1);

    logic [CNT_W-1:0]  div_int_q, div_int_d;
    logic [FRAC_W-1:0] div_frac_q, div_frac_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;
    logic              wr_err_q, wr_err_d;

    logic [CNT_W:0]    period_m1;
    logic              bit_end;
    logic              last_bit;
    logic [CNT_W-1:0]  tick_pos;
    logic [FRAC_W:0]   frac_sum;

    // One extra bit so a full-scale divisor plus carry cannot wrap the compare.
    assign period_m1 = {1'b0, div_int_q} + (CNT_W+1)'(ext_q) - (CNT_W+1)'(1);
    assign bit_end   = ({1'b0, count_q} == period_m1);
    assign last_bit  = (idx_q == LastIdx);
    assign tick_pos  = Phase_Mode ? '0 : (div_int_q >> 1);
    assign frac_sum  = {1'b0, acc_q} + {1'b0, div_frac_q};

    always_comb begin
        div_int_d  = div_int_q;
        div_frac_d = div_frac_q;
        count_d    = count_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        ext_d      = ext_q;
        wr_err_d   = Div_Wr & Count_Sig;

        if (Div_Wr && !Count_Sig) begin
            div_int_d  = (Div_Int < DivMin) ? DivMin : Div_Int;
            div_frac_d = Div_Frac;
        end

        if (!Count_Sig) begin
            count_d = '0;
            idx_d   = '0;
            acc_d   = '0;
            ext_d   = 1'b0;
        end else if (bit_end) begin
            count_d        = '0;
            {ext_d, acc_d} = frac_sum;
            idx_d          = last_bit ? '0 : idx_q + IDX_W'(1);
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            div_int_q  <= DivDefault;
            div_frac_q <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            ext_q      <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            div_int_q  <= div_int_d;
            div_frac_q <= div_frac_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            ext_q      <= ext_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // Strobes are held low while reset is asserted even if the enable is high.
    assign BPS_CLK    = RSTn & Count_Sig & (count_q == tick_pos);
    assign Frame_Done = RSTn & Count_Sig & bit_end & last_bit;
    assign Bit_Idx    = idx_q;
    assign Wr_Err     = wr_err_q;

endmodule
